io_debounce: RTL and testbench

IO_DEBOUNCE -- requirements
Module: io_debounce

---
 rtl/io_debounce_pkg.sv | 19 +
 rtl/io_sync2.sv | 27 ++
 rtl/io_debounce.sv | 148 ++++++++++++++
 tb/tb_io_debounce.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/io_debounce_pkg.sv
// Shared types and helpers for the io_debounce block.
package io_debounce_pkg;

  // Debounce FSM states.
  typedef enum logic [1:0] {
    ST_RELEASED     = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } db_state_e;

  // Counter width able to hold 0..n, never narrower than one bit.
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/io_sync2.sv
// Two-flop synchronizer for asynchronous inputs, cleared to zero on reset.
module io_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Two back-to-back capture stages.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/io_debounce.sv
// Pad debouncer: synchronizes raw_i, accepts a level change only after
// DEBOUNCE_CYCLES stable samples, and optionally auto-repeats while held.
module io_debounce
  import io_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_CYCLES   = 0
) (
  input  logic wb_clk_i,
  input  logic wb_rst_i,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic pulse_o,
  output logic glitch_o
);

  localparam int CNT_W  = cnt_width(DEBOUNCE_CYCLES);
  localparam int RCNT_W = cnt_width(REPEAT_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RCNT_W-1:0] RPT_LAST =
    RCNT_W'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);

  logic              sync_q;
  db_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [RCNT_W-1:0] rcnt_q, rcnt_d;
  logic              tick_q, tick_d;
  logic              level_q, level_d;
  logic              rise_q, rise_d;
  logic              fall_q, fall_d;
  logic              pulse_q, pulse_d;
  logic              glitch_q, glitch_d;
  logic              held_q, held_d;

  io_sync2 #(.WIDTH(1)) u_sync (
    .clk_i (wb_clk_i),
    .rst_i (wb_rst_i),
    .d_i   (raw_i),
    .q_o   (sync_q)
  );

  // Next-state, debounce counter and glitch detection.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    glitch_d = 1'b0;
    case (state_q)
      ST_RELEASED: begin
        if (sync_q) begin
          state_d = ST_PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (!sync_q) begin
          state_d  = ST_RELEASED;
          cnt_d    = '0;
          glitch_d = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_PRESSED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_PRESSED: begin
        if (!sync_q) begin
          state_d = ST_RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      ST_RELEASE_WAIT: begin
        if (sync_q) begin
          state_d  = ST_PRESSED;
          cnt_d    = '0;
          glitch_d = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_RELEASED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

  // Registered outputs derived from the upcoming state; repeat counter.
  always_comb begin
    held_q  = (state_q == ST_PRESSED) || (state_q == ST_RELEASE_WAIT);
    held_d  = (state_d == ST_PRESSED) || (state_d == ST_RELEASE_WAIT);
    level_d = held_d;
    rise_d  = (state_q == ST_PRESS_WAIT) && (state_d == ST_PRESSED);
    fall_d  = (state_q == ST_RELEASE_WAIT) && (state_d == ST_RELEASED);
    rcnt_d  = '0;
    tick_d  = 1'b0;
    // Entering PRESSED (acceptance or aborted release) restarts the period.
    if ((state_d == ST_PRESSED) && (state_q != ST_PRESSED)) begin
      rcnt_d = '0;
    end else if (held_q && (REPEAT_CYCLES > 0)) begin
      if (rcnt_q == RPT_LAST) begin
        rcnt_d = '0;
        tick_d = held_d;
      end else begin
        rcnt_d = rcnt_q + RCNT_W'(1);
      end
    end
    // A tick is delayed one cycle, so it can never land on a rise cycle.
    pulse_d = rise_d | tick_q;
  end

  // State and output registers.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= ST_RELEASED;
      cnt_q    <= '0;
      rcnt_q   <= '0;
      tick_q   <= 1'b0;
      level_q  <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      pulse_q  <= 1'b0;
      glitch_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rcnt_q   <= rcnt_d;
      tick_q   <= tick_d;
      level_q  <= level_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      pulse_q  <= pulse_d;
      glitch_q <= glitch_d;
    end
  end

  assign level_o  = level_q;
  assign rise_o   = rise_q;
  assign fall_o   = fall_q;
  assign pulse_o  = pulse_q;
  assign glitch_o = glitch_q;

endmodule

// File: tb/tb_io_debounce.sv
// Self-checking bench: two instances (4/8 and 1/0) share stimulus; a
// run-length behavioural model predicts every output on every cycle.
module tb_io_debounce;

  logic clk;
  logic rst;
  logic raw;

  logic a_level, a_rise, a_fall, a_pulse, a_glitch;
  logic b_level, b_rise, b_fall, b_pulse, b_glitch;

  int n_checks = 0;
  int n_fail   = 0;

  io_debounce #(.DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(8)) u_a (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .raw_i    (raw),
    .level_o  (a_level),
    .rise_o   (a_rise),
    .fall_o   (a_fall),
    .pulse_o  (a_pulse),
    .glitch_o (a_glitch)
  );

  io_debounce #(.DEBOUNCE_CYCLES(1), .REPEAT_CYCLES(0)) u_b (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .raw_i    (raw),
    .level_o  (b_level),
    .rise_o   (b_rise),
    .fall_o   (b_fall),
    .pulse_o  (b_pulse),
    .glitch_o (b_glitch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: a change is accepted after D+1 consecutive edges
  // on which the synchronized input differs from the accepted level; a
  // shorter run that ends early is a glitch. While held, a tick is
  // produced every R edges counted from entry into the pressed level.
  typedef struct packed {
    logic s1;
    logic s2;
    logic level;
    int   run;
    int   age;
    logic tick;
    logic rise;
    logic fall;
    logic pulse;
    logic glitch;
  } mstate_t;

  function automatic mstate_t model_step(input mstate_t m, input logic r,
                                         input logic rs, input int d,
                                         input int rp);
    mstate_t n;
    logic    s;
    n = m;
    if (rs) begin
      n = '0;
      return n;
    end
    s        = m.s2;
    n.s2     = m.s1;
    n.s1     = r;
    n.rise   = 1'b0;
    n.fall   = 1'b0;
    n.glitch = 1'b0;
    if (s != m.level) begin
      n.run = m.run + 1;
      if (n.run == d + 1) begin
        n.level = s;
        n.run   = 0;
        n.rise  = s;
        n.fall  = !s;
      end
    end else begin
      n.glitch = (m.run > 0);
      n.run    = 0;
    end
    n.pulse = n.rise | m.tick;
    if (n.rise || (n.glitch && m.level)) begin
      n.age  = 0;
      n.tick = 1'b0;
    end else if (m.level && rp > 0) begin
      n.age  = m.age + 1;
      n.tick = 1'b0;
      if (n.age == rp) begin
        n.age  = 0;
        n.tick = n.level;
      end
    end else begin
      n.age  = 0;
      n.tick = 1'b0;
    end
    return n;
  endfunction

  mstate_t m_a = '0;
  mstate_t m_b = '0;

  always @(posedge clk) begin
    m_a <= model_step(m_a, raw, rst, 4, 8);
    m_b <= model_step(m_b, raw, rst, 1, 0);
  end

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: wait to the falling edge, then compare every output.
  task automatic step();
    @(negedge clk);
    check("a_level",  a_level,  m_a.level);
    check("a_rise",   a_rise,   m_a.rise);
    check("a_fall",   a_fall,   m_a.fall);
    check("a_pulse",  a_pulse,  m_a.pulse);
    check("a_glitch", a_glitch, m_a.glitch);
    check("b_level",  b_level,  m_b.level);
    check("b_rise",   b_rise,   m_b.rise);
    check("b_fall",   b_fall,   m_b.fall);
    check("b_pulse",  b_pulse,  m_b.pulse);
    check("b_glitch", b_glitch, m_b.glitch);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst = 1'b1;
    raw = 1'b0;
    steps(2);
    check("rst_a_level", a_level, 1'b0);
    check("rst_a_pulse", a_pulse, 1'b0);
    check("rst_b_level", b_level, 1'b0);
    rst = 1'b0;
    steps(3);
    $display("reset: checks=%0d fails=%0d", n_checks, n_fail);

    // Clean press, long hold with repeat, then release.
    raw = 1'b1;
    steps(3);
    check("b_rise_e3", b_rise, 1'b0);
    step();
    check("b_rise_e4", b_rise, 1'b1);
    steps(2);
    check("a_level_e6", a_level, 1'b0);
    step();
    check("a_rise_e7",  a_rise,  1'b1);
    check("a_pulse_e7", a_pulse, 1'b1);
    check("a_level_e7", a_level, 1'b1);
    for (int e = 8; e <= 45; e++) begin
      step();
      if (e == 16 || e == 24 || e == 32 || e == 40)
        check("a_repeat_tick", a_pulse, 1'b1);
      if (e == 15 || e == 23 || e == 17)
        check("a_repeat_gap", a_pulse, 1'b0);
    end
    $display("press+hold: checks=%0d fails=%0d", n_checks, n_fail);
    raw = 1'b0;
    steps(6);
    check("a_level_rel6", a_level, 1'b1);
    step();
    check("a_fall_rel7",  a_fall,  1'b1);
    check("a_level_rel7", a_level, 1'b0);
    steps(12);
    $display("release: checks=%0d fails=%0d", n_checks, n_fail);

    // Bounce: high 3, low 1, then held high.
    raw = 1'b1;
    steps(3);
    raw = 1'b0;
    step();
    raw = 1'b1;
    step();
    step();
    check("a_glitch_e6", a_glitch, 1'b1);
    steps(4);
    check("a_rise_e10", a_rise, 1'b0);
    step();
    check("a_rise_e11", a_rise, 1'b1);
    steps(5);
    raw = 1'b0;
    steps(12);
    $display("bounce: checks=%0d fails=%0d", n_checks, n_fail);

    // Reset while the press is still being debounced (cnt=2).
    raw = 1'b1;
    steps(5);
    rst = 1'b1;
    step();
    check("rstmid_a_level",  a_level,  1'b0);
    check("rstmid_a_glitch", a_glitch, 1'b0);
    check("rstmid_b_level",  b_level,  1'b0);
    check("rstmid_b_fall",   b_fall,   1'b0);
    rst = 1'b0;
    step();
    check("rstmid_a_glitch_after", a_glitch, 1'b0);
    steps(5);
    check("rstmid_a_rise_e12", a_rise, 1'b0);
    step();
    check("rstmid_a_rise_e13", a_rise, 1'b1);
    steps(4);
    raw = 1'b0;
    steps(12);
    $display("reset mid-debounce: checks=%0d fails=%0d", n_checks, n_fail);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
